// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one sequential Booth multiplier between NUM_REQ requesters.
// Define BOOTH_ARB_TIMEOUT_EN to abort a WAIT that sees no mul_done within TIMEOUT_CYC cycles.
module booth_mult_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]      req_a,
    input  logic [NUM_REQ*WIDTH-1:0]      req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic signed [2*WIDTH-1:0]     rsp_y,
    output logic                          rsp_err,
    output logic                          mul_start,
    output logic signed [WIDTH-1:0]       mul_a,
    output logic signed [WIDTH-1:0]       mul_b,
    input  logic                          mul_done,
    input  logic signed [2*WIDTH-1:0]     mul_y,
    output logic                          busy
);
    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("booth_mult_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                  state;
    logic [ID_W-1:0]         ptr;
    logic [ID_W-1:0]         grant_id;
    logic [ID_W-1:0]         sel;
    logic [NUM_REQ-1:0]      grant;
    logic                    found;
    logic                    accept;
    logic signed [WIDTH-1:0] a_sel;
    logic signed [WIDTH-1:0] b_sel;
    int                      idx;

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = 0;
        sel      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = ID_W'(idx);
            if (!found && req_valid[sel]) begin
                found    = 1'b1;
                grant_id = sel;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign grant     = found ? (NUM_REQ'(1) << grant_id) : '0;
    assign req_ready = (state == S_IDLE && !rst) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= ID_W'(NUM_REQ - 1);
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
            busy      <= 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mul_a     <= a_sel;
                        mul_b     <= b_sel;
                        rsp_id    <= grant_id;
                        ptr       <= grant_id;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mul_start <= 1'b0;
                    state     <= S_WAIT;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                end
                S_WAIT: begin
                    // A done on the expiry cycle still delivers the real product.
                    if (mul_done) begin
                        rsp_y     <= mul_y;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
`ifdef BOOTH_ARB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rsp_y     <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a multiplier stub that answers 5 cycles after mul_start.
module tb_booth_mult_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_y;
    logic        rsp_err;
    logic        mul_start;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic        mul_done = 1'b0;
    logic [7:0]  mul_y = 8'hA5;
    logic        busy;

    logic        stub_en = 1'b1;
    logic [2:0]  stub_cnt = 3'd0;
    logic [7:0]  stub_y = 8'h00;

    int checks   = 0;
    int failures = 0;

    booth_mult_arbiter #(.NUM_REQ(4), .WIDTH(4), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_y(mul_y), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier stub: done pulses in the 5th cycle after the start cycle.
    always @(posedge clk) begin
        mul_done <= 1'b0;
        mul_y    <= 8'hA5;
        if (mul_start && stub_en) begin
            stub_cnt <= 3'd4;
            stub_y   <= 8'(8'($signed(mul_a)) * 8'($signed(mul_b)));
        end else if (stub_cnt != 3'd0) begin
            stub_cnt <= stub_cnt - 3'd1;
            if (stub_cnt == 3'd1) begin
                mul_done <= 1'b1;
                mul_y    <= stub_y;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int id, input logic [3:0] a, input logic [3:0] b);
        req_a[id*4 +: 4] = a;
        req_b[id*4 +: 4] = b;
    endtask

    // One full transaction; req_valid=mask stays driven when the task returns.
    task automatic serve(input string tag, input logic [3:0] mask, input int exp_id,
                         input logic [3:0] a_exp, input logic [3:0] b_exp,
                         input logic [7:0] y_exp, input int hold);
        int n;
        int extra;
        req_valid = mask;
        #1;
        chk({tag, ":req_ready"}, 32'(req_ready), 32'(1) << exp_id);
        tick();
        chk({tag, ":mul_start"}, 32'(mul_start), 32'd1);
        chk({tag, ":mul_a"}, 32'(mul_a), 32'(a_exp));
        chk({tag, ":mul_b"}, 32'(mul_b), 32'(b_exp));
        chk({tag, ":busy"}, 32'(busy), 32'd1);
        chk({tag, ":ready_issue"}, 32'(req_ready), 32'd0);
        n = 0;
        extra = 0;
        do begin
            tick();
            n++;
            if (mul_start) extra++;
        end while (!rsp_valid && n < 30);
        chk({tag, ":latency"}, 32'(n), 32'd6);
        chk({tag, ":start_pulses"}, 32'(extra), 32'd0);
        chk({tag, ":rsp_id"}, 32'(rsp_id), 32'(exp_id));
        chk({tag, ":rsp_y"}, 32'(rsp_y), 32'(y_exp));
        chk({tag, ":rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, ":ready_resp"}, 32'(req_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, ":hold_id"}, 32'(rsp_id), 32'(exp_id));
            chk({tag, ":hold_y"}, 32'(rsp_y), 32'(y_exp));
            chk({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, ":valid_after"}, 32'(rsp_valid), 32'd0);
        chk({tag, ":busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        int n;
        rst       = 1'b0;
        req_valid = 4'b0000;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        rsp_ready = 1'b0;

        #1 rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("reset:req_ready", 32'(req_ready), 32'd0);
        chk("reset:rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset:busy", 32'(busy), 32'd0);
        chk("reset:mul_start", 32'(mul_start), 32'd0);
        chk("reset:mul_a", 32'(mul_a), 32'd0);
        chk("reset:mul_b", 32'(mul_b), 32'd0);
        chk("reset:rsp_id", 32'(rsp_id), 32'd0);
        chk("reset:rsp_y", 32'(rsp_y), 32'd0);
        chk("reset:rsp_err", 32'(rsp_err), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        req_valid = 4'b0000;

        // Single request: 3 * -2 = -6
        set_op(0, 4'h3, 4'hE);
        serve("t1", 4'b0001, 0, 4'h3, 4'hE, 8'hFA, 0);
        req_valid = 4'b0000;

        // Fairness between two held requesters: 2*3=6, -3*5=-15
        set_op(1, 4'h2, 4'h3);
        set_op(3, 4'hD, 4'h5);
        serve("rr_a", 4'b1010, 1, 4'h2, 4'h3, 8'h06, 0);
        serve("rr_b", 4'b1010, 3, 4'hD, 4'h5, 8'hF1, 0);
        serve("rr_c", 4'b1010, 1, 4'h2, 4'h3, 8'h06, 0);
        serve("rr_d", 4'b1010, 3, 4'hD, 4'h5, 8'hF1, 0);
        req_valid = 4'b0000;

        // All four after a reset: order 0,1,2,3 (7*7=49)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_op(2, 4'h7, 4'h7);
        serve("all0", 4'b1111, 0, 4'h3, 4'hE, 8'hFA, 0);
        serve("all1", 4'b1111, 1, 4'h2, 4'h3, 8'h06, 0);
        serve("all2", 4'b1111, 2, 4'h7, 4'h7, 8'h31, 0);
        serve("all3", 4'b1111, 3, 4'hD, 4'h5, 8'hF1, 0);
        req_valid = 4'b0000;

        // Response back-pressure for 10 cycles
        serve("bp", 4'b0100, 2, 4'h7, 4'h7, 8'h31, 10);
        req_valid = 4'b0000;

        // Operand extremes: -8*-8=64, -8*7=-56, 0*-1=0
        set_op(0, 4'h8, 4'h8);
        serve("min_min", 4'b0001, 0, 4'h8, 4'h8, 8'h40, 0);
        req_valid = 4'b0000;
        set_op(0, 4'h8, 4'h7);
        serve("min_max", 4'b0001, 0, 4'h8, 4'h7, 8'hC8, 0);
        req_valid = 4'b0000;
        set_op(0, 4'h0, 4'hF);
        serve("zero", 4'b0001, 0, 4'h0, 4'hF, 8'h00, 0);
        req_valid = 4'b0000;

        // Reset while waiting for the multiplier
        req_valid = 4'b0010;
        #1;
        chk("rstwait:grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        chk("rstwait:busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        req_valid = 4'b0101;
        #1;
        chk("rstwait:busy", 32'(busy), 32'd0);
        chk("rstwait:rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstwait:mul_a", 32'(mul_a), 32'd0);
        chk("rstwait:mul_b", 32'(mul_b), 32'd0);
        chk("rstwait:rsp_id", 32'(rsp_id), 32'd0);
        chk("rstwait:req_ready", 32'(req_ready), 32'd0);
        chk("rstwait:mul_start", 32'(mul_start), 32'd0);
        tick();
        rst = 1'b0;
        req_valid = 4'b0000;
        seen = 0;
        repeat (8) begin
            tick();
            if (rsp_valid || busy || mul_start) seen++;
        end
        chk("rstwait:late_done_ignored", 32'(seen), 32'd0);
        req_valid = 4'b0101;
        #1;
        chk("rstwait:next_grant", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;

        // Multiplier that never answers
        stub_en = 1'b0;
        set_op(0, 4'h1, 4'h1);
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = 4'b0000;
        chk("nodone:mul_start", 32'(mul_start), 32'd1);
`ifdef BOOTH_ARB_TIMEOUT_EN
        n = 0;
        do begin
            tick();
            n++;
        end while (!rsp_valid && n < 40);
        chk("timeout:latency", 32'(n), 32'd16);
        chk("timeout:rsp_y", 32'(rsp_y), 32'd0);
        chk("timeout:rsp_err", 32'(rsp_err), 32'd1);
        chk("timeout:rsp_id", 32'(rsp_id), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("timeout:valid_after", 32'(rsp_valid), 32'd0);
`else
        n = 0;
        seen = 0;
        repeat (40) begin
            tick();
            n++;
            if (rsp_valid) seen++;
        end
        chk("nodone:no_response", 32'(seen), 32'd0);
        chk("nodone:still_busy", 32'(busy), 32'd1);
        chk("nodone:rsp_err", 32'(rsp_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
